// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: parses SPI command frames into compare/enable registers and drives N_CH PWM outputs.
// Optional macro PWM_SYNC_UPDATE_EN: compare values pass through shadows that load only at the period wrap.
module pwm_multi_ch #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int PERIOD = 30000
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  input  logic            cs_n,
  output logic [N_CH-1:0] pwm_out,
  output logic            period_tick,
  output logic            cmd_done,
  output logic            frame_err
);
  // state   | meaning
  // IDLE    | waiting for a header byte
  // CMP_HI  | expecting compare high byte
  // CMP_LO  | expecting compare low byte, commit on receipt
  // MASK    | expecting enable mask byte, commit on receipt
  // DISCARD | bad header seen, drop bytes until cs_n goes high
  typedef enum logic [2:0] {IDLE, CMP_HI, CMP_LO, MASK, DISCARD} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  state_t           state_q, state_d;
  logic [1:0]       cs_sync;
  logic             cs_s;
  logic [3:0]       ch_q;
  logic [7:0]       hi_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp [N_CH];
  logic [N_CH-1:0]  en;
  logic [CNT_W-1:0] cmp_val;
  logic             wrap;
  logic             cmp_wr, en_wr, hi_wr, hdr_wr, done_d, err_d;

  assign cs_s    = cs_sync[1];
  assign wrap    = (cnt == LAST);
  assign cmp_val = CNT_W'({hi_q, rx_data});

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) cs_sync <= 2'b11;
    else     cs_sync <= {cs_sync[0], cs_n};
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cmp_wr  = 1'b0;
    en_wr   = 1'b0;
    hi_wr   = 1'b0;
    hdr_wr  = 1'b0;
    if (cs_s) begin
      // Deselect mid-frame drops the partial frame without touching registers.
      state_d = IDLE;
      if (state_q inside {CMP_HI, CMP_LO, MASK}) err_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data[7:4] == 4'h1 && rx_data[3:0] < 4'(N_CH)) begin
            state_d = CMP_HI;
            hdr_wr  = 1'b1;
          end else if (rx_data[7:4] == 4'h2) begin
            state_d = MASK;
          end else begin
            state_d = DISCARD;
            err_d   = 1'b1;
          end
        end
        CMP_HI: begin
          hi_wr   = 1'b1;
          state_d = CMP_LO;
        end
        CMP_LO: begin
          cmp_wr  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        MASK: begin
          en_wr   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        DISCARD: state_d = DISCARD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      hi_q      <= '0;
      en        <= '0;
      cmd_done  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_done  <= done_d;
      frame_err <= err_d;
      if (hdr_wr) ch_q <= rx_data[3:0];
      if (hi_wr)  hi_q <= rx_data;
      if (en_wr)  en   <= rx_data[N_CH-1:0];
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  logic [CNT_W-1:0] shadow [N_CH];

  // A write landing on the wrap cycle misses this load and applies next period.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        cmp[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cmp_wr && ch_q == 4'(i)) shadow[i] <= cmp_val;
        if (wrap) cmp[i] <= shadow[i];
      end
    end
  end
`else
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cmp[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cmp_wr && ch_q == 4'(i)) cmp[i] <= cmp_val;
      end
    end
  end
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
    end else begin
      cnt         <= wrap ? '0 : cnt + CNT_W'(1);
      period_tick <= wrap;
      for (int i = 0; i < N_CH; i++) pwm_out[i] <= en[i] & (cnt < cmp[i]);
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed frames against a cycle-index model of pwm_multi_ch (PERIOD=100, N_CH=4).
// Honours PWM_SYNC_UPDATE_EN the same way the design does.
module tb_pwm_multi_ch;
  localparam int P = 100;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] pwm_out;
  logic       period_tick, cmd_done, frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: k counts clock edges since reset release, so the counter is k mod P.
  int         k;
  logic [3:0] m_en;
  int         m_cmp [4];
  int         m_shadow [4];
  logic [3:0] exp_pwm;
  logic       exp_tick, exp_done, exp_err;

  bit         pend_done, pend_err, pend_cw, pend_ew;
  int         pend_ch, pend_val;
  logic [3:0] pend_em;

  int acc [4];
  int last_hi [4];
  int done_cnt = 0;
  int err_cnt  = 0;

  pwm_multi_ch #(.N_CH(4), .CNT_W(16), .PERIOD(P)) dut (
    .CLK(CLK), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .cs_n(cs_n),
    .pwm_out(pwm_out), .period_tick(period_tick), .cmd_done(cmd_done), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      k <= 0; m_en <= '0; exp_pwm <= '0;
      exp_tick <= 1'b0; exp_done <= 1'b0; exp_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_cmp[i] <= 0;
        m_shadow[i] <= 0;
      end
    end else begin
      k <= k + 1;
      for (int i = 0; i < 4; i++) exp_pwm[i] <= m_en[i] && ((k % P) < m_cmp[i]);
      exp_tick <= ((k + 1) % P) == 0;
      exp_done <= pend_done;
      exp_err  <= pend_err;
      if (pend_ew) m_en <= pend_em;
`ifdef PWM_SYNC_UPDATE_EN
      if (pend_cw) m_shadow[pend_ch] <= pend_val;
      if ((k % P) == P - 1) for (int i = 0; i < 4; i++) m_cmp[i] <= m_shadow[i];
`else
      if (pend_cw) m_cmp[pend_ch] <= pend_val;
`endif
    end
  end

  always @(negedge CLK) begin
    n_tests++;
    if ({pwm_out, period_tick, cmd_done, frame_err} !== {exp_pwm, exp_tick, exp_done, exp_err}) begin
      n_fail++;
      $display("FAIL cycle_cmp k=%0d: pwm=%b tick=%b done=%b err=%b, expected pwm=%b tick=%b done=%b err=%b",
               k, pwm_out, period_tick, cmd_done, frame_err, exp_pwm, exp_tick, exp_done, exp_err);
    end
  end

  // Per-period high counts: the tick-cycle output still belongs to the previous period.
  always @(negedge CLK) begin
    done_cnt <= done_cnt + int'(cmd_done);
    err_cnt  <= err_cnt + int'(frame_err);
    for (int i = 0; i < 4; i++) begin
      if (period_tick) begin
        last_hi[i] <= acc[i] + int'(pwm_out[i]);
        acc[i] <= 0;
      end else begin
        acc[i] <= acc[i] + int'(pwm_out[i]);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit done = 0, input bit err = 0,
                           input bit cw = 0, input int ch = 0, input int val = 0,
                           input bit ew = 0, input logic [3:0] em = 4'h0);
    @(negedge CLK);
    rx_data = b; rx_valid = 1'b1;
    pend_done = done; pend_err = err; pend_cw = cw; pend_ch = ch; pend_val = val;
    pend_ew = ew; pend_em = em;
    @(negedge CLK);
    rx_valid = 1'b0;
    pend_done = 0; pend_err = 0; pend_cw = 0; pend_ew = 0;
  endtask

  task automatic frame_cmp(input int ch, input int val);
    send_byte(8'h10 | 8'(ch));
    send_byte(8'(val >> 8));
    send_byte(8'(val), 1, 0, 1, ch, val);
  endtask

  task automatic frame_mask(input logic [3:0] m);
    send_byte(8'h20);
    send_byte({4'h0, m}, 1, 0, 0, 0, 0, 1, m);
  endtask

  task automatic cs_low();
    @(negedge CLK); cs_n = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic cs_high();
    @(negedge CLK); cs_n = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  // Raw rise, two synchroniser edges, then the error registers on the third edge.
  task automatic cs_abort();
    @(negedge CLK); cs_n = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_err_early", int'(frame_err), 0);
    pend_err = 1;
    @(negedge CLK);
    pend_err = 0;
    #1 check("abort_err_lat", int'(frame_err), 1);
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * P && !seen; i++) begin
      @(negedge CLK);
      if (period_tick) seen = 1;
    end
    #1;
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_cnt(input int c);
    bit hit = 0;
    for (int i = 0; i <= P && !hit; i++) begin
      @(negedge CLK);
      if (k % P == c) hit = 1;
    end
    if (!hit) check("wait_cnt_timeout", 0, 1);
  endtask

  initial begin
    int d0, e0, lat;
    bit seen;
    pend_done = 0; pend_err = 0; pend_cw = 0; pend_ew = 0; pend_ch = 0; pend_val = 0; pend_em = '0;
    for (int i = 0; i < 4; i++) begin
      acc[i] = 0;
      last_hi[i] = 0;
    end
    #1 rst = 1'b1;
    #2 check("reset_pwm", int'(pwm_out), 0);
    check("reset_flags", int'({period_tick, cmd_done, frame_err}), 0);
    repeat (3) @(negedge CLK);
    rst = 1'b0;

    // Mask all, channel 2 = 25.
    #1 d0 = done_cnt;
    cs_low();
    send_byte(8'h20);
    send_byte(8'h0F, 1, 0, 0, 0, 0, 1, 4'hF);
    send_byte(8'h12);
    send_byte(8'h00);
    send_byte(8'h19, 1, 0, 1, 2, 25);
    cs_high();
    #1 check("t1_done_pulses", done_cnt - d0, 2);
    wait_tick(); wait_tick();
    check("t1_ch2_high", last_hi[2], 25);
    check("t1_ch0_high", last_hi[0], 0);
    check("t1_ch1_high", last_hi[1], 0);
    check("t1_ch3_high", last_hi[3], 0);

    // Compare 0 and PERIOD extremes.
    cs_low();
    frame_cmp(0, 0);
    frame_cmp(1, 100);
    frame_mask(4'h3);
    cs_high();
    wait_tick();
    for (int p = 0; p < 3; p++) begin
      wait_tick();
      check("t2_ch0_const_low", last_hi[0], 0);
      check("t2_ch1_const_high", last_hi[1], 100);
    end

    // Mid-period update 25 -> 75, low byte sampled at cnt=50.
    cs_low();
    frame_cmp(0, 25);
    frame_mask(4'h1);
    wait_tick(); wait_tick();
    check("t3_before", last_hi[0], 25);
    send_byte(8'h10);
    send_byte(8'h00);
    wait_cnt(49);
    send_byte(8'd75, 1, 0, 1, 0, 75);
    wait_tick();
`ifdef PWM_SYNC_UPDATE_EN
    check("t3_cur_period", last_hi[0], 25);
`else
    check("t3_cur_period", last_hi[0], 49);
`endif
    wait_tick();
    check("t3_next_period", last_hi[0], 75);
    cs_high();

    // Bad command, then out-of-range channel; trailing bytes must be dropped.
    #1 d0 = done_cnt; e0 = err_cnt;
    cs_low();
    send_byte(8'h35, 0, 1);
    send_byte(8'h12);
    send_byte(8'h00);
    send_byte(8'h40);
    cs_high();
    cs_low();
    send_byte(8'h17, 0, 1);
    send_byte(8'h20);
    send_byte(8'h00);
    cs_high();
    #1 check("t4_err_pulses", err_cnt - e0, 2);
    check("t4_no_done", done_cnt - d0, 0);
    wait_tick(); wait_tick();
    check("t4_ch0_kept", last_hi[0], 75);

    // Truncated frame aborted by cs_n, then a clean frame.
    cs_low();
    frame_mask(4'h3);
    send_byte(8'h11);
    send_byte(8'h00);
    cs_abort();
    wait_tick(); wait_tick();
    check("t5_cmp1_kept", last_hi[1], 100);
    cs_low();
    frame_cmp(1, 64);
    cs_high();
    wait_tick(); wait_tick();
    check("t5_cmp1_new", last_hi[1], 64);

    // Asynchronous reset mid-period with all channels high.
    cs_low();
    frame_cmp(3, 50);
    frame_mask(4'hF);
    cs_high();
    wait_tick(); wait_tick();
    wait_cnt(10);
    #1 check("t6_all_high", int'(pwm_out), 15);
    #1 rst = 1'b1;
    #1 check("t6_rst_pwm", int'(pwm_out), 0);
    @(negedge CLK);
    rst = 1'b0;
    seen = 0; lat = 0;
    for (int i = 1; i <= 2 * P && !seen; i++) begin
      @(negedge CLK);
      if (period_tick) begin
        seen = 1;
        lat = i;
      end
    end
    check("t6_restart_tick", lat, P);

    repeat (2) @(negedge CLK);
    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Multi-channel PWM generator programmed over SPI. Sits behind `spi_slave` in the SPI/PWM design and consumes its received-byte stream (`rx_data`, `rx_valid`). It parses short command frames into per-channel compare registers and an enable mask, then drives `N_CH` glitch-free PWM outputs from one shared period counter. Defaults give a 400 Hz refresh from a 12 MHz `CLK`.

## Interface
- `N_CH`, 4: number of PWM channels, 1..8
- `CNT_W`, 16: width of the period counter and of the compare registers
- `PERIOD`, 30000: counter modulus in `CLK` cycles, 2..2^CNT_W-1 (12 MHz / 400 Hz)

- `CLK` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `rx_data` in 8: byte from `spi_slave`, valid when `rx_valid` is high
- `rx_valid` in 1: single-cycle strobe per received byte, `CLK` domain
- `cs_n` in 1: raw SPI chip select; synchronised internally with 2 flops
- `pwm_out` out N_CH: PWM outputs, registered
- `period_tick` out 1: one-cycle pulse when the counter wraps to 0
- `cmd_done` out 1: one-cycle pulse when a valid frame is committed
- `frame_err` out 1: one-cycle pulse on a bad header or a truncated frame

## Operation
- Frame format: header byte, then data bytes, all inside one `cs_n`-low window.
- Header bits [7:4] hold the command; bits [3:0] hold the channel.
- Command 0x1 writes a compare value. Two data bytes follow, high then low. The value is the low `CNT_W` bits of {hi, lo}.
- Command 0x2 writes the enable mask. One data byte follows; bits [N_CH-1:0] go to `en`. The channel field is ignored.
- Parser FSM states: IDLE, CMP_HI, CMP_LO, MASK, DISCARD.
  - IDLE, header 0x1 with channel < N_CH: go to CMP_HI.
  - IDLE, header 0x2: go to MASK.
  - IDLE, any other header: pulse `frame_err`, go to DISCARD.
  - CMP_HI, byte received: latch hi byte, go to CMP_LO.
  - CMP_LO, byte received: write `shadow[ch]`, pulse `cmd_done`, go to IDLE.
  - MASK, byte received: write `en`, pulse `cmd_done`, go to IDLE.
  - DISCARD: ignore all bytes until synchronised `cs_n` is high.
- Synchronised `cs_n` high forces IDLE from any state. If the FSM was in CMP_HI, CMP_LO or MASK, pulse `frame_err`; the partial frame is dropped and no register changes.
- Extra bytes after a completed frame in the same `cs_n` window are parsed as a new header.
- Counter `cnt` runs 0..PERIOD-1 and wraps to 0. `period_tick` is high in the cycle `cnt`==0.
- Output rule: `pwm_out[i]` = `en[i]` AND (`cnt` < `cmp[i]`), registered.
  - `cmp` = 0 gives constant low.
  - `cmp` >= PERIOD gives constant high while enabled.
  - Clearing `en[i]` forces `pwm_out[i]` low on the next cycle, mid-period.

## Timing
- Reset values:
  - `pwm_out`=0, `period_tick`=0, `cmd_done`=0, `frame_err`=0.
  - `cnt`=0, all `shadow`/`cmp`=0, `en`=0, FSM=IDLE, `cs_n` synchroniser=1.
- After reset release, `cnt` starts counting on the first `CLK` edge.
- `rx_valid` to register write: the register updates on the clock edge that samples `rx_valid`. `cmd_done` and `frame_err` are high in the following cycle.
- `pwm_out` lags `cnt` by one cycle. Its high time is exactly `cmp[i]` cycles per period when 0 < `cmp[i]` < PERIOD.
- `cs_n` abort takes effect 2 cycles after the raw `cs_n` rises.
- `rst` asserted mid-frame or mid-period clears all state immediately, asynchronously. There is no partial commit.
- A `shadow` write and a counter wrap in the same cycle: the wrap loads the pre-write `shadow` value. The new value applies from the following period.

## Configuration
- `PWM_SYNC_UPDATE_EN` defined:
  - `cmp[i]` loads from `shadow[i]` only in the cycle `cnt` goes PERIOD-1 to 0.
  - Every period uses a single compare value, so there are no runt pulses.
- `PWM_SYNC_UPDATE_EN` undefined:
  - `shadow` is bypassed; `cmp[i]` is written directly on the CMP_LO byte.
  - The new value applies from the next counter cycle, and a mid-period glitch is permitted.

## Test plan
All scenarios use PERIOD=100, CNT_W=16, N_CH=4.
- Reset, then frames {0x20, 0x0F} and {0x12, 0x00, 0x19}: `pwm_out[2]` is high 25 of every 100 cycles; the other outputs stay 0; `cmd_done` pulses twice.
- Compare values 0 and 100 on channels 0 and 1, mask 0x03: `pwm_out[0]` is constant 0 and `pwm_out[1]` is constant 1 across 3 periods.
- With `PWM_SYNC_UPDATE_EN`, `cmp` 25 to 75 written at `cnt`=50: the current period keeps 25 high cycles and the next period has 75. Without the macro, the current period's high time changes immediately.
- Header 0x35 (bad command), then header 0x17 (channel 7 >= N_CH): `frame_err` pulses each time, the following bytes are ignored, and the registers are unchanged.
- {0x11, 0x00} followed by `cs_n` rising: `frame_err` pulses 1 cycle after the abort (3 cycles after raw `cs_n` rises), `cmp[1]` is unchanged, and the next header parses normally.
- `rst` pulsed mid-period with all channels active: all outputs go 0 immediately and `cnt` restarts at 0.
